// File: rtl/ckpt_mon_pkg.sv
// rtl/ckpt_mon_pkg.sv - shared state encoding and default checkpoint codes
// Purpose: FSM state type and default signature constants used by the
//          checkpoint monitor and anything that programs it.
// Ports:   none (package)
package ckpt_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ckpt_state_e;

  localparam logic [15:0] CKPT_START    = 16'hAB60;
  localparam logic [15:0] CKPT_END      = 16'hAB64;
  localparam logic [15:0] CKPT_END_MASK = 16'hFFFC;
  localparam logic [15:0] PASS_MASK     = 16'h0002;

endpackage

// File: rtl/sig_stability_filter.sv
// rtl/sig_stability_filter.sv - glitch filter for the observed signature bus
// Purpose: registers the signature bus and flags it stable once it has held
//          the same value for STABLE_CYC extra cycles.
// Ports:   clock, resetb (async active-low), sig_in (raw bus),
//          sig_q (registered bus), stable (sig_q has settled)
module sig_stability_filter #(
  parameter int SIG_W      = 16,
  parameter int STABLE_CYC = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [SIG_W-1:0] sig_in,
  output logic [SIG_W-1:0] sig_q,
  output logic             stable
);

  localparam int CNT_W = (STABLE_CYC > 0) ? $clog2(STABLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  logic [CNT_W-1:0] stab_cnt;

  // The counter restarts whenever the incoming value differs from the
  // registered one and saturates at CNT_MAX, so stable stays high for as
  // long as the bus holds.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sig_q    <= '0;
      stab_cnt <= '0;
    end else begin
      sig_q <= sig_in;
      if (sig_in != sig_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

  assign stable = (stab_cnt == CNT_MAX);

endmodule

// File: rtl/wb_checkpoint_monitor.sv
// rtl/wb_checkpoint_monitor.sv - ordered checkpoint sequencer with timeout and verdict
// Purpose: follows a signature bus through NUM_CKPT masked checkpoint codes in
//          order, times out each step, and checks the final code against a
//          masked pass value.
// Ports:   clock, resetb (async active-low), enable (run / abort),
//          sig_in (signature bus), ckpt_code/ckpt_mask (packed per-checkpoint
//          code and compare mask), pass_mask/pass_val (final check),
//          timeout_limit (cycles per checkpoint, 0 = off),
//          busy, done, pass, fail, timed_out, ckpt_idx (progress/verdict)
module wb_checkpoint_monitor
  import ckpt_mon_pkg::*;
#(
  parameter int SIG_W      = 16,
  parameter int NUM_CKPT   = 4,
  parameter int TIMEOUT_W  = 24,
  parameter int STABLE_CYC = 2
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic [SIG_W-1:0]              sig_in,
  input  logic [NUM_CKPT*SIG_W-1:0]     ckpt_code,
  input  logic [NUM_CKPT*SIG_W-1:0]     ckpt_mask,
  input  logic [SIG_W-1:0]              pass_mask,
  input  logic [SIG_W-1:0]              pass_val,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timed_out,
  output logic [$clog2(NUM_CKPT+1)-1:0] ckpt_idx
);

  localparam int IDX_W = $clog2(NUM_CKPT + 1);

  ckpt_state_e          state, state_d;
  logic [IDX_W-1:0]     idx_d;
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_d, tmo_inc;
  logic                 pass_d, fail_d, tflag_d;

  logic [SIG_W-1:0]     sig_q;
  logic                 stable;
  logic [SIG_W-1:0]     cur_code, cur_mask;
  logic                 hit, last, tmo_expire, verdict;

  sig_stability_filter #(
    .SIG_W      (SIG_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clock  (clock),
    .resetb (resetb),
    .sig_in (sig_in),
    .sig_q  (sig_q),
    .stable (stable)
  );

  // Only the current checkpoint is selected; once ckpt_idx reaches NUM_CKPT
  // the mask falls to zero, which is harmless because DONE ignores hit.
  always_comb begin
    cur_code = '0;
    cur_mask = '0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (ckpt_idx == IDX_W'(k)) begin
        cur_code = ckpt_code[k*SIG_W +: SIG_W];
        cur_mask = ckpt_mask[k*SIG_W +: SIG_W];
      end
    end
  end

  assign hit        = stable && (((sig_q ^ cur_code) & cur_mask) == '0);
  assign last       = (ckpt_idx == IDX_W'(NUM_CKPT - 1));
  assign tmo_expire = (timeout_limit != '0) &&
                      (tmo_cnt == timeout_limit - TIMEOUT_W'(1));
  assign tmo_inc    = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TIMEOUT_W'(1);
  assign verdict    = ((sig_q & pass_mask) == pass_val);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      ckpt_idx  <= '0;
      tmo_cnt   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_d;
      ckpt_idx  <= idx_d;
      tmo_cnt   <= tmo_d;
      pass      <= pass_d;
      fail      <= fail_d;
      timed_out <= tflag_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = ckpt_idx;
    tmo_d   = tmo_cnt;
    pass_d  = pass;
    fail_d  = fail;
    tflag_d = timed_out;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      tmo_d   = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      tflag_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_RUN;
          idx_d   = '0;
          tmo_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tflag_d = 1'b0;
        end
        ST_RUN: begin
          tmo_d = tmo_inc;
          // hit is tested first so a match on the expiry cycle still counts
          if (hit) begin
            if (last) begin
              state_d = ST_DONE;
              idx_d   = IDX_W'(NUM_CKPT);
              pass_d  = verdict;
              fail_d  = !verdict;
            end else begin
              idx_d = ckpt_idx + IDX_W'(1);
              tmo_d = '0;
            end
          end else if (tmo_expire) begin
            state_d = ST_DONE;
            fail_d  = 1'b1;
            tflag_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
